// File: rtl/ws2812_stream_loader_if.sv
// Byte-stream valid/ready handshake feeding the ws2812 stream loader.
// The master produces bytes; the slave (the loader) reports readiness.
interface ws2812_stream_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ws2812_stream_loader.sv
// Packs a byte stream into 24-bit colour writes for the ws2812 driver, using an
// idle gap on the stream to delimit frames and realign the byte/LED pointers.
module ws2812_stream_loader #(
    parameter int NUM_LEDS       = 8,
    parameter int CLK_MHZ        = 10,
    parameter int TIMEOUT_CYCLES = CLK_MHZ * 100
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ws2812_stream_loader_if.slave  stream,
    output logic [23:0]            rgb_data,
    output logic [7:0]             led_num,
    output logic                   write,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   short_frame
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LAST_LED = 8'(NUM_LEDS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       byte_idx;
    logic [7:0]       led_ptr;
    logic [CNT_W-1:0] idle_cnt;
    logic [15:0]      shift_reg;
    logic             ready_q;
    logic             accept;
    logic             timeout;

    assign stream.in_ready = ready_q;
    assign accept  = stream.in_valid && ready_q;
    // An accepted byte always wins over an expiring idle counter.
    assign timeout = !accept && (state != S_IDLE) && (idle_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            byte_idx    <= 2'd0;
            led_ptr     <= 8'd0;
            idle_cnt    <= '0;
            shift_reg   <= 16'd0;
            ready_q     <= 1'b0;
            rgb_data    <= 24'd0;
            led_num     <= 8'd0;
            write       <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            write       <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;

            if (accept) begin
                idle_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        shift_reg <= {shift_reg[7:0], stream.in_data};
                        byte_idx  <= 2'd1;
                        state     <= S_COLLECT;
                    end
                    S_COLLECT: begin
                        if (byte_idx == 2'd2) begin
                            rgb_data <= {shift_reg, stream.in_data};
                            led_num  <= led_ptr;
                            write    <= 1'b1;
                            byte_idx <= 2'd0;
                            if (led_ptr == LAST_LED) begin
                                frame_done <= 1'b1;
                                state      <= S_DISCARD;
                            end else begin
                                led_ptr <= led_ptr + 8'd1;
                            end
                        end else begin
                            shift_reg <= {shift_reg[7:0], stream.in_data};
                            byte_idx  <= byte_idx + 2'd1;
                        end
                    end
                    S_DISCARD: overflow <= 1'b1;
                    default:   state    <= S_IDLE;
                endcase
            end else if (timeout) begin
                // A frame that ended while still collecting is reported as short.
                if (state == S_COLLECT) begin
                    short_frame <= 1'b1;
                end
                state    <= S_IDLE;
                byte_idx <= 2'd0;
                led_ptr  <= 8'd0;
                idle_cnt <= '0;
                overflow <= 1'b0;
            end else if (state != S_IDLE) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/ws2812_stream_loader.md
# ws2812_stream_loader

Upstream feeder for the ws2812 serial driver. Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake, packs every three bytes into one 24-bit colour word and issues single-cycle writes to the driver's `rgb_data`/`led_num`/`write` port, walking LED indices 0..NUM_LEDS-1. An idle gap on the stream delimits frames and realigns the byte and LED pointers, so a sender that loses sync recovers on the next frame.

## Interface

**Parameters**
- `NUM_LEDS`, 8: LEDs per frame; must match the driver's `NUM_LEDS`; range 1..256.
- `CLK_MHZ`, 10: clock frequency in MHz.
- `TIMEOUT_CYCLES`, `CLK_MHZ*100`: idle cycles (100 us by default) that end a frame; minimum 2.

**Ports**
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `rgb_data` output 24: packed colour. The first byte of a triplet maps to [23:16], the second to [15:8], the third to [7:0].
- `led_num` output 8: target LED index.
- `write` output 1: one-cycle write strobe to the driver.
- `frame_done` output 1: one-cycle pulse, coincident with the write for LED NUM_LEDS-1.
- `overflow` output 1: sticky; bytes were dropped because the frame was already full.
- `short_frame` output 1: one-cycle pulse; a frame timed out before all LEDs were written.

## Operation

- **Accept:** a byte is accepted on a rising edge where `in_valid && in_ready`.
- **`in_ready`:** 0 while in reset. It goes 1 on the first edge after `reset_n` deasserts and then stays 1 (there is no backpressure).
- **Internal state:** state register {IDLE, COLLECT, DISCARD}; `byte_idx` (0..2); `led_ptr` (0..NUM_LEDS-1); `idle_cnt` (width `$clog2(TIMEOUT_CYCLES)`); 16-bit shift register holding the first two bytes of a triplet.
- **IDLE:** pointers are 0. An accepted byte is stored, sets `byte_idx` to 1 and moves the state to COLLECT.
- **COLLECT:**
  - Accepted bytes 0 and 1 are stored and `byte_idx` increments.
  - An accepted byte at `byte_idx`==2 drives, on the next edge: `rgb_data` = {b0, b1, b2}, `led_num` = `led_ptr`, `write` = 1. `byte_idx` returns to 0.
  - If `led_ptr` == NUM_LEDS-1: `frame_done` = 1 with that write, and the state moves to DISCARD. Otherwise `led_ptr` increments.
- **DISCARD:** bytes are still accepted but dropped; each dropped byte sets `overflow`. No writes are issued.
- **`idle_cnt`:** clears on every accepted byte. It increments on every non-accepting cycle while the state is not IDLE.
- **Timeout:** fires on an edge where no byte is accepted and `idle_cnt` == TIMEOUT_CYCLES-1. On that edge:
  - state goes to IDLE; `byte_idx`, `led_ptr` and `idle_cnt` go to 0;
  - `overflow` clears;
  - if the state was COLLECT, `short_frame` pulses; any partial triplet is discarded.
- **Simultaneous accept and timeout condition:** the accept wins. The counter clears and no timeout fires.
- **Output hold:** `rgb_data` and `led_num` hold their values between writes.
- **No ready input from the driver:** the driver accepts writes on every cycle.

## Timing

- **Reset values:** all outputs are 0 while `reset_n` is low, and state is IDLE. Reset mid-triplet discards it and no write occurs. The driver's memory is unaffected.
- **Write latency:** `write` is high for exactly one cycle, starting one cycle after the edge that accepted the third byte of a triplet.
- **Minimum write spacing:** 3 cycles (back-to-back bytes).
- **Frame boundary:** exactly TIMEOUT_CYCLES consecutive non-accepting cycles after the last accepted byte end the frame. A gap of TIMEOUT_CYCLES-1 cycles does not.
- **Pulse widths:** `frame_done` and `short_frame` are each one cycle, registered. `short_frame` is asserted in the cycle after the timeout edge.

## Test plan

Bench parameters: NUM_LEDS=4, TIMEOUT_CYCLES=20.

1. **Reset:** hold `reset_n` low, `in_valid`=1 → all outputs 0, no accept; `in_ready`=1 one edge after release.
2. **Full frame:** 12 back-to-back bytes 0x01..0x0C →
   - writes (`led_num`, `rgb_data`): (0, 0x010203), (1, 0x040506), (2, 0x070809), (3, 0x0A0B0C);
   - each write arrives one cycle after its third byte;
   - `frame_done` coincides with the LED 3 write.
3. **Overflow:** 14 bytes →
   - 4 writes, bytes 13–14 dropped, `overflow`=1;
   - after 20 idle cycles `overflow`=0 and no `short_frame`;
   - next bytes 0xAA 0xBB 0xCC → write (0, 0xAABBCC).
4. **Short frame:** 5 bytes then a 20-cycle gap → only write (0, …); `short_frame` pulses once; the next triplet writes LED 0.
5. **Gap boundary:**
   - 19-cycle gap after byte 2 → no timeout, the triplet completes to LED 0;
   - a 20-cycle gap at the same point → the partial triplet is dropped.
6. **Reset mid-triplet:** pulse `reset_n` low after the 2nd byte → no write; after release, 3 bytes → write (0, …).
